// File: rtl/axi_bridge_pkg.sv
// rtl/axi_bridge_pkg.sv - shared AXI read-bridge IDs, fixed AR fields and FSM states
package axi_bridge_pkg;

  localparam logic [3:0] AXI_ID_INST = 4'd0;
  localparam logic [3:0] AXI_ID_DATA = 4'd1;

  localparam logic [7:0] AR_LEN   = 8'd0;
  localparam logic [1:0] AR_BURST = 2'b01;
  localparam logic [1:0] AR_LOCK  = 2'b00;
  localparam logic [3:0] AR_CACHE = 4'b0000;
  localparam logic [2:0] AR_PROT  = 3'b000;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_AR_SEND = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rd_outstanding_ctr.sv
// rtl/rd_outstanding_ctr.sv - in-flight read counter for one AXI ID, saturating at zero
module rd_outstanding_ctr #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic clk,
  input  logic resetn,
  input  logic inc,
  input  logic dec,
  output logic full
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (inc && !dec) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (dec && !inc && (r_cnt != '0)) begin
      // Stray returns (e.g. from before a reset) must not wrap the count.
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign full = (r_cnt >= CNT_W'(MAX_OUTSTANDING));

endmodule

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - shares one AXI AR/R channel between inst and data read ports
// Optional build macro AXI_ARB_ROUND_ROBIN_EN selects round-robin instead of data-first priority.
module axi_rd_arbiter
  import axi_bridge_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_rreq,
  input  logic [31:0] inst_raddr,
  input  logic [1:0]  inst_rsize,
  output logic        inst_raddr_ok,
  output logic        inst_rdata_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_rreq,
  input  logic [31:0] data_raddr,
  input  logic [1:0]  data_rsize,
  output logic        data_raddr_ok,
  output logic        data_rdata_ok,
  output logic [31:0] data_rdata,
  input  logic        wr_pending,
  input  logic [31:0] wr_addr,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  arb_state_e  r_state;
  arb_state_e  w_next_state;
  logic [31:0] r_araddr;
  logic [3:0]  r_arid;
  logic [1:0]  r_size;

  logic w_inst_full, w_data_full;
  logic w_inst_elig, w_data_elig, w_data_raw_hit;
  logic w_pick_data, w_grant_inst, w_grant_data;
  logic w_inst_ret, w_data_ret;

  // A data read to the word of an un-acknowledged write would return stale data.
  assign w_data_raw_hit = wr_pending && (((data_raddr ^ wr_addr) & 32'hFFFF_FFFC) == 32'd0);
  assign w_inst_elig    = inst_rreq && !w_inst_full;
  assign w_data_elig    = data_rreq && !w_data_full && !w_data_raw_hit;

`ifdef AXI_ARB_ROUND_ROBIN_EN
  logic r_last_grant;  // 0 = inst, 1 = data

  assign w_pick_data = w_data_elig && (!w_inst_elig || !r_last_grant);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last_grant <= 1'b0;
    end else if (w_grant_inst || w_grant_data) begin
      r_last_grant <= w_grant_data;
    end
  end
`else
  assign w_pick_data = w_data_elig;
`endif

  assign w_grant_data = (r_state == ST_IDLE) && w_pick_data;
  assign w_grant_inst = (r_state == ST_IDLE) && w_inst_elig && !w_pick_data;

  always_comb begin
    w_next_state  = r_state;
    inst_raddr_ok = 1'b0;
    data_raddr_ok = 1'b0;
    arvalid       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        inst_raddr_ok = w_grant_inst;
        data_raddr_ok = w_grant_data;
        if (w_grant_inst || w_grant_data) begin
          w_next_state = ST_AR_SEND;
        end
      end
      ST_AR_SEND: begin
        arvalid = 1'b1;
        if (arready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_araddr <= 32'd0;
      r_arid   <= 4'd0;
      r_size   <= 2'd0;
    end else begin
      r_state <= w_next_state;
      if (w_grant_data) begin
        r_araddr <= data_raddr;
        r_arid   <= AXI_ID_DATA;
        r_size   <= data_rsize;
      end else if (w_grant_inst) begin
        r_araddr <= inst_raddr;
        r_arid   <= AXI_ID_INST;
        r_size   <= inst_rsize;
      end
    end
  end

  assign w_inst_ret = rvalid && rlast && (rid == AXI_ID_INST);
  assign w_data_ret = rvalid && rlast && (rid == AXI_ID_DATA);

  rd_outstanding_ctr #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CNT_W           (CNT_W)
  ) u_inst_ctr (
    .clk    (clk),
    .resetn (resetn),
    .inc    (w_grant_inst),
    .dec    (w_inst_ret),
    .full   (w_inst_full)
  );

  rd_outstanding_ctr #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CNT_W           (CNT_W)
  ) u_data_ctr (
    .clk    (clk),
    .resetn (resetn),
    .inc    (w_grant_data),
    .dec    (w_data_ret),
    .full   (w_data_full)
  );

  assign arid    = r_arid;
  assign araddr  = r_araddr;
  assign arsize  = {1'b0, r_size};
  assign arlen   = AR_LEN;
  assign arburst = AR_BURST;
  assign arlock  = AR_LOCK;
  assign arcache = AR_CACHE;
  assign arprot  = AR_PROT;

  assign rready        = 1'b1;
  assign inst_rdata_ok = rvalid && (rid == AXI_ID_INST);
  assign data_rdata_ok = rvalid && (rid == AXI_ID_DATA);
  assign inst_rdata    = rdata;
  assign data_rdata    = rdata;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - directed self-checking bench for axi_rd_arbiter (MAX_OUTSTANDING=2)
module tb_axi_rd_arbiter;

  logic        clk, resetn;
  logic        inst_rreq, inst_raddr_ok, inst_rdata_ok;
  logic [31:0] inst_raddr, inst_rdata;
  logic [1:0]  inst_rsize;
  logic        data_rreq, data_raddr_ok, data_rdata_ok;
  logic [31:0] data_raddr, data_rdata;
  logic [1:0]  data_rsize;
  logic        wr_pending;
  logic [31:0] wr_addr;
  logic [3:0]  arid, arcache;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, arlock;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  int n_chk = 0;
  int n_bad = 0;

  axi_rd_arbiter #(.MAX_OUTSTANDING(2)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .inst_rreq     (inst_rreq),
    .inst_raddr    (inst_raddr),
    .inst_rsize    (inst_rsize),
    .inst_raddr_ok (inst_raddr_ok),
    .inst_rdata_ok (inst_rdata_ok),
    .inst_rdata    (inst_rdata),
    .data_rreq     (data_rreq),
    .data_raddr    (data_raddr),
    .data_rsize    (data_rsize),
    .data_raddr_ok (data_raddr_ok),
    .data_rdata_ok (data_rdata_ok),
    .data_rdata    (data_rdata),
    .wr_pending    (wr_pending),
    .wr_addr       (wr_addr),
    .arid          (arid),
    .araddr        (araddr),
    .arlen         (arlen),
    .arsize        (arsize),
    .arburst       (arburst),
    .arlock        (arlock),
    .arcache       (arcache),
    .arprot        (arprot),
    .arvalid       (arvalid),
    .arready       (arready),
    .rid           (rid),
    .rdata         (rdata),
    .rresp         (rresp),
    .rlast         (rlast),
    .rvalid        (rvalid),
    .rready        (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ret_beat(input logic [3:0] id, input logic [31:0] d, input int n);
    rvalid = 1'b1; rid = id; rlast = 1'b1; rdata = d;
    repeat (n) tick();
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; inst_rreq = 1'b0; inst_raddr = '0; inst_rsize = '0;
    data_rreq = 1'b0; data_raddr = '0; data_rsize = '0;
    wr_pending = 1'b0; wr_addr = '0; arready = 1'b1;
    rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;

    repeat (2) tick();
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_arid", 32'(arid), 32'd0);
    chk("rst_arsize", 32'(arsize), 32'd0);
    chk("rst_rready", 32'(rready), 32'd1);
    chk("rst_arlen", 32'(arlen), 32'd0);
    chk("rst_arburst", 32'(arburst), 32'd1);
    chk("rst_arfix", 32'({arlock, arcache, arprot}), 32'd0);
    resetn = 1'b1;
    tick();

    // 1: single instruction read
    inst_rreq = 1'b1; inst_raddr = 32'h1C00_0000; inst_rsize = 2'd2;
    #1;
    chk("t1_inst_ok", 32'(inst_raddr_ok), 32'd1);
    chk("t1_data_ok", 32'(data_raddr_ok), 32'd0);
    tick();
    inst_rreq = 1'b0;
    #1;
    chk("t1_arvalid", 32'(arvalid), 32'd1);
    chk("t1_arid", 32'(arid), 32'd0);
    chk("t1_arsize", 32'(arsize), 32'd2);
    chk("t1_araddr", araddr, 32'h1C00_0000);
    tick();
    chk("t1_arvalid_off", 32'(arvalid), 32'd0);
    rvalid = 1'b1; rid = 4'd0; rlast = 1'b1; rdata = 32'hDEAD_BEEF;
    #1;
    chk("t1_rdata_ok", 32'(inst_rdata_ok), 32'd1);
    chk("t1_rdata", inst_rdata, 32'hDEAD_BEEF);
    chk("t1_d_rdata_ok", 32'(data_rdata_ok), 32'd0);
    tick();
    rvalid = 1'b0; rlast = 1'b0;

    // 2: simultaneous requests, data first
    inst_rreq = 1'b1; data_rreq = 1'b1; data_raddr = 32'h8000_0000; data_rsize = 2'd2;
    #1;
    chk("t2_data_ok", 32'(data_raddr_ok), 32'd1);
    chk("t2_inst_ok", 32'(inst_raddr_ok), 32'd0);
    tick();
    data_rreq = 1'b0;
    #1;
    chk("t2_arid1", 32'(arid), 32'd1);
    chk("t2_araddr1", araddr, 32'h8000_0000);
    chk("t2_no_ok_send", 32'(inst_raddr_ok), 32'd0);
    tick();
    chk("t2_inst_ok2", 32'(inst_raddr_ok), 32'd1);
    tick();
    inst_rreq = 1'b0;
    #1;
    chk("t2_arid0", 32'(arid), 32'd0);
    tick();
    rvalid = 1'b1; rid = 4'd1; rlast = 1'b1; rdata = 32'h1234_5678;
    #1;
    chk("t2_d_rdata_ok", 32'(data_rdata_ok), 32'd1);
    chk("t2_d_rdata", data_rdata, 32'h1234_5678);
    chk("t2_i_rdata_ok", 32'(inst_rdata_ok), 32'd0);
    tick();
    rid = 4'd0;
    tick();
    rid = 4'd5;
    #1;
    chk("t2_other_i", 32'(inst_rdata_ok), 32'd0);
    chk("t2_other_d", 32'(data_rdata_ok), 32'd0);
    tick();
    rvalid = 1'b0; rlast = 1'b0;

    // 3: outstanding limit, grant+return, underflow guard
    inst_rreq = 1'b1; inst_raddr = 32'h1C00_0010;
    #1; chk("t3_g1", 32'(inst_raddr_ok), 32'd1);
    tick(); chk("t3_send", 32'(inst_raddr_ok), 32'd0);
    tick(); chk("t3_g2", 32'(inst_raddr_ok), 32'd1);
    tick(); tick(); chk("t3_full", 32'(inst_raddr_ok), 32'd0);
    tick(); chk("t3_full2", 32'(inst_raddr_ok), 32'd0);
    rvalid = 1'b1; rid = 4'd0; rlast = 1'b1;
    #1;
    chk("t3_full_ret", 32'(inst_raddr_ok), 32'd0);
    chk("t3_ret_ok", 32'(inst_rdata_ok), 32'd1);
    tick();
    chk("t3_grant_ret", 32'(inst_raddr_ok), 32'd1);
    tick();
    rvalid = 1'b0; rlast = 1'b0;
    tick(); chk("t3_after_gr", 32'(inst_raddr_ok), 32'd1);
    tick(); tick(); chk("t3_full3", 32'(inst_raddr_ok), 32'd0);
    inst_rreq = 1'b0;
    ret_beat(4'd0, 32'd0, 3);
    inst_rreq = 1'b1;
    #1; chk("t3_nouf_g1", 32'(inst_raddr_ok), 32'd1);
    tick(); tick(); chk("t3_nouf_g2", 32'(inst_raddr_ok), 32'd1);
    tick(); tick(); chk("t3_nouf_full", 32'(inst_raddr_ok), 32'd0);
    inst_rreq = 1'b0;
    ret_beat(4'd0, 32'd0, 2);

    // 4: read-after-write hazard
    wr_pending = 1'b1; wr_addr = 32'h8000_1008;
    data_rreq = 1'b1; data_raddr = 32'h8000_1006; data_rsize = 2'd1;
    #1; chk("t4_other_word", 32'(data_raddr_ok), 32'd1);
    wr_addr = 32'h8000_1004;
    inst_rreq = 1'b1; inst_raddr = 32'h1C00_0020;
    #1;
    chk("t4_blocked", 32'(data_raddr_ok), 32'd0);
    chk("t4_inst_won", 32'(inst_raddr_ok), 32'd1);
    tick();
    inst_rreq = 1'b0;
    tick();
    chk("t4_still_blk", 32'(data_raddr_ok), 32'd0);
    wr_pending = 1'b0;
    #1; chk("t4_released", 32'(data_raddr_ok), 32'd1);
    tick();
    data_rreq = 1'b0;
    #1;
    chk("t4_arid", 32'(arid), 32'd1);
    chk("t4_araddr", araddr, 32'h8000_1006);
    chk("t4_arsize", 32'(arsize), 32'd1);
    tick();
    ret_beat(4'd0, 32'd0, 1);
    ret_beat(4'd1, 32'd0, 1);

    // 5: AR backpressure
    arready = 1'b0;
    inst_rreq = 1'b1; inst_raddr = 32'h0000_0040; inst_rsize = 2'd1;
    #1; chk("t5_grant", 32'(inst_raddr_ok), 32'd1);
    tick();
    inst_rreq = 1'b0; data_rreq = 1'b1; data_raddr = 32'h8000_2000;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t5_arvalid", 32'(arvalid), 32'd1);
      chk("t5_araddr", araddr, 32'h0000_0040);
      chk("t5_arid", 32'(arid), 32'd0);
      chk("t5_arsize", 32'(arsize), 32'd1);
      chk("t5_no_ok", 32'(data_raddr_ok), 32'd0);
      tick();
    end
    arready = 1'b1; data_rreq = 1'b0;
    tick();
    chk("t5_idle", 32'(arvalid), 32'd0);
    data_rreq = 1'b1;
    #1; chk("t5_data_ok", 32'(data_raddr_ok), 32'd1);
    data_rreq = 1'b0;
    ret_beat(4'd0, 32'd0, 1);

    // 6: reset during AR_SEND
    arready = 1'b0;
    inst_rreq = 1'b1; inst_raddr = 32'h1C00_0030; inst_rsize = 2'd2;
    tick();
    inst_rreq = 1'b0;
    #1; chk("t6_arvalid", 32'(arvalid), 32'd1);
    resetn = 1'b0;
    #1;
    chk("t6_rst_arvalid", 32'(arvalid), 32'd0);
    chk("t6_rst_araddr", araddr, 32'd0);
    chk("t6_rst_arid", 32'(arid), 32'd0);
    chk("t6_rst_arsize", 32'(arsize), 32'd0);
    tick();
    resetn = 1'b1; arready = 1'b1; inst_rreq = 1'b1;
    #1; chk("t6_g1", 32'(inst_raddr_ok), 32'd1);
    tick(); tick(); chk("t6_g2", 32'(inst_raddr_ok), 32'd1);
    tick(); tick(); chk("t6_full", 32'(inst_raddr_ok), 32'd0);
    inst_rreq = 1'b0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
